// File: rtl/taumin_pkg.sv
// ---------------------------------------------------------------------------
// taumin_pkg
// Shared definitions for the taumin_tracker post-processor and its median
// sorter: tracker FSM states, history length and sort pass count.
// No ports (package).
// ---------------------------------------------------------------------------
package taumin_pkg;

  // Number of accepted estimates kept in the history / sorted for the median
  localparam int MEDIAN_LEN  = 5;

  // Odd-even transposition passes needed to fully order MEDIAN_LEN entries
  localparam int SORT_PASSES = 5;

  // Width of the pass counter that walks through SORT_PASSES
  localparam int PASS_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    EMIT
  } tracker_state_t;

endpackage : taumin_pkg

// File: rtl/median5_sorter.sv
// ---------------------------------------------------------------------------
// median5_sorter
// Five sort registers ordered by alternating odd/even compare-swap passes.
// A load copies the five inputs in and restarts on an even pass; each step
// performs one pass. After MEDIAN_LEN steps the taps are ascending, so tap 2
// is the median.
//
// Ports:
//   clk_in   in   1                     clock
//   rst_in   in   1                     synchronous active-low reset
//   load_in  in   1                     copy data_in into the sort registers
//   step_in  in   1                     perform one transposition pass
//   data_in  in   WIDTH x MEDIAN_LEN    values to sort
//   tap_out  out  WIDTH x MEDIAN_LEN    sort registers, ascending when done
// ---------------------------------------------------------------------------
module median5_sorter
  import taumin_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic             step_in,
  input  logic [WIDTH-1:0] data_in [MEDIAN_LEN],
  output logic [WIDTH-1:0] tap_out [MEDIAN_LEN]
);

  logic [WIDTH-1:0] sort_q [MEDIAN_LEN];
  logic [WIDTH-1:0] sort_d [MEDIAN_LEN];
  logic             odd_q;

  // One transposition pass: even passes pair (0,1),(2,3), odd passes pair
  // (1,2),(3,4). The pairs in a pass never overlap, so they swap in parallel.
  always_comb begin
    sort_d = sort_q;
    for (int i = 0; i < MEDIAN_LEN - 1; i++) begin
      if ((i % 2) == int'(odd_q)) begin
        if (sort_q[i] > sort_q[i+1]) begin
          sort_d[i]   = sort_q[i+1];
          sort_d[i+1] = sort_q[i];
        end
      end
    end
  end

  // Sort registers and pass parity; a load always restarts on an even pass
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < MEDIAN_LEN; i++) begin
        sort_q[i] <= '0;
      end
      odd_q <= 1'b0;
    end else if (load_in) begin
      sort_q <= data_in;
      odd_q  <= 1'b0;
    end else if (step_in) begin
      sort_q <= sort_d;
      odd_q  <= ~odd_q;
    end
  end

  assign tap_out = sort_q;

endmodule : median5_sorter

// File: rtl/taumin_tracker.sv
// ---------------------------------------------------------------------------
// taumin_tracker
// Cleans the raw period estimates from yin before they reach the bufferizer:
// rejects out-of-range periods, median-filters the last five accepted ones,
// and holds the last good period across short dropouts. Every input strobe
// yields exactly one output strobe seven cycles later.
//
// Ports:
//   clk_in            in   1      system clock
//   rst_in            in   1      synchronous active-low reset
//   taumin_in         in   WIDTH  raw period estimate
//   taumin_valid_in   in   1      single-cycle strobe qualifying taumin_in
//   taumin_out        out  WIDTH  cleaned period
//   taumin_valid_out  out  1      single-cycle strobe for taumin_out/voiced_out
//   voiced_out        out  1      history holds at least one accepted estimate
//   overrun_out       out  1      sticky: strobe arrived while busy
// ---------------------------------------------------------------------------
module taumin_tracker
  import taumin_pkg::*;
#(
  parameter int WIDTH      = 11,
  parameter int TAU_LO     = 20,
  parameter int TAU_HI     = 2000,
  parameter int HOLD_COUNT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] taumin_in,
  input  logic             taumin_valid_in,
  output logic [WIDTH-1:0] taumin_out,
  output logic             taumin_valid_out,
  output logic             voiced_out,
  output logic             overrun_out
);

  localparam logic [WIDTH-1:0]  TAU_LO_W  = WIDTH'(TAU_LO);
  localparam logic [WIDTH-1:0]  TAU_HI_W  = WIDTH'(TAU_HI);
  localparam logic [7:0]        HOLD_MISS = 8'(HOLD_COUNT);
  localparam logic [2:0]        FILL_FULL = 3'(MEDIAN_LEN);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(SORT_PASSES - 1);

  tracker_state_t state_q, state_d;

  logic [WIDTH-1:0]  hist_q [MEDIAN_LEN];
  logic [WIDTH-1:0]  hist_d [MEDIAN_LEN];
  logic [2:0]        fill_q, fill_d;
  logic [7:0]        miss_q, miss_d;
  logic [PASS_W-1:0] pass_q;

  logic [WIDTH-1:0]  taumin_q;
  logic              valid_q;
  logic              voiced_q;
  logic              overrun_q;

  logic              strobe_taken;
  logic              accept;
  logic              sort_load;
  logic              sort_step;
  logic              emit;
  logic [WIDTH-1:0]  taps [MEDIAN_LEN];
  logic [WIDTH-1:0]  result;

  assign strobe_taken = taumin_valid_in && (state_q == IDLE);
  assign accept       = (taumin_in >= TAU_LO_W) && (taumin_in <= TAU_HI_W);

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every strobe walks the full LOAD/SORT/EMIT path, even when
  // the median is not used, so the latency never depends on the history.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (taumin_valid_in) state_d = LOAD;
      LOAD: state_d = SORT;
      SORT: if (pass_q == LAST_PASS) state_d = EMIT;
      EMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sort_load = (state_q == LOAD);
    sort_step = (state_q == SORT);
    emit      = (state_q == EMIT);
  end

  // History update on a taken strobe. The miss counter saturates at
  // HOLD_COUNT, and reaching it forgets the history by clearing fill; the
  // stored values stay but are no longer counted.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    miss_d = miss_q;
    if (strobe_taken) begin
      if (accept) begin
        hist_d[0] = taumin_in;
        for (int i = 1; i < MEDIAN_LEN; i++) begin
          hist_d[i] = hist_q[i-1];
        end
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 3'd1;
        end
        miss_d = '0;
      end else begin
        if (miss_q != HOLD_MISS) begin
          miss_d = miss_q + 8'd1;
        end
        if (miss_d == HOLD_MISS) begin
          fill_d = '0;
        end
      end
    end
  end

  median5_sorter #(
    .WIDTH (WIDTH)
  ) u_sorter (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load_in (sort_load),
    .step_in (sort_step),
    .data_in (hist_q),
    .tap_out (taps)
  );

  // Result selection: median once the history is full, newest entry while
  // filling, and the previous output when nothing valid remains.
  always_comb begin
    if (fill_q == FILL_FULL) begin
      result = taps[2];
    end else if (fill_q != 3'd0) begin
      result = hist_q[0];
    end else begin
      result = taumin_q;
    end
  end

  // Datapath registers: history, counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < MEDIAN_LEN; i++) begin
        hist_q[i] <= '0;
      end
      fill_q    <= '0;
      miss_q    <= '0;
      pass_q    <= '0;
      taumin_q  <= '0;
      valid_q   <= 1'b0;
      voiced_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      miss_q <= miss_d;
      if (sort_load) begin
        pass_q <= '0;
      end else if (sort_step) begin
        pass_q <= pass_q + 1'b1;
      end
      valid_q <= emit;
      if (emit) begin
        taumin_q <= result;
        voiced_q <= (fill_q != 3'd0);
      end
      if (taumin_valid_in && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign taumin_out       = taumin_q;
  assign taumin_valid_out = valid_q;
  assign voiced_out       = voiced_q;
  assign overrun_out      = overrun_q;

endmodule : taumin_tracker

// File: tb/tb_taumin_tracker.sv
// ---------------------------------------------------------------------------
// tb_taumin_tracker
// Self-checking bench for taumin_tracker: directed vector table, randomized
// stimulus against a behavioural model, and hand-timed overrun/reset cases.
// ---------------------------------------------------------------------------
module tb_taumin_tracker;

  logic        clk_in;
  logic        rst_in;
  logic [10:0] taumin_in;
  logic        taumin_valid_in;
  logic [10:0] taumin_out;
  logic        taumin_valid_out;
  logic        voiced_out;
  logic        overrun_out;

  int checkCount = 0;
  int failCount  = 0;

  taumin_tracker #(
    .WIDTH      (11),
    .TAU_LO     (20),
    .TAU_HI     (2000),
    .HOLD_COUNT (8)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .taumin_in        (taumin_in),
    .taumin_valid_in  (taumin_valid_in),
    .taumin_out       (taumin_out),
    .taumin_valid_out (taumin_valid_out),
    .voiced_out       (voiced_out),
    .overrun_out      (overrun_out)
  );

  // 100 MHz clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Behavioural reference: newest-first history, fill and miss counts
  int mHist [5];
  int mFill;
  int mMiss;
  int mLast;

  function automatic void modelReset();
    for (int i = 0; i < 5; i++) mHist[i] = 0;
    mFill = 0;
    mMiss = 0;
    mLast = 0;
  endfunction

  // Median as the element with at most two smaller and at least three
  // smaller-or-equal entries
  function automatic int modelMedian();
    int med = 0;
    for (int i = 0; i < 5; i++) begin
      int lt = 0;
      int le = 0;
      for (int j = 0; j < 5; j++) begin
        if (mHist[j] < mHist[i])  lt++;
        if (mHist[j] <= mHist[i]) le++;
      end
      if (lt <= 2 && le >= 3) med = mHist[i];
    end
    return med;
  endfunction

  function automatic void modelStep(input int tau, output int expOut, output bit expVoiced);
    if (tau >= 20 && tau <= 2000) begin
      for (int i = 4; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = tau;
      mFill = (mFill < 5) ? mFill + 1 : 5;
      mMiss = 0;
    end else begin
      mMiss = (mMiss < 8) ? mMiss + 1 : 8;
      if (mMiss == 8) mFill = 0;
    end
    if (mFill == 5)      mLast = modelMedian();
    else if (mFill != 0) mLast = mHist[0];
    expOut    = mLast;
    expVoiced = (mFill != 0);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst_in = 1'b0;
    taumin_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    modelReset();
  endtask

  // Drives one strobe (optionally releasing reset on the same cycle) and
  // waits a bounded number of cycles for the output pulse; latency is the
  // number of clock edges after the sampling edge, 0 if none came.
  task automatic applyStimulus(input int tau, input bit releaseReset, output int latency);
    @(negedge clk_in);
    if (releaseReset) rst_in = 1'b1;
    taumin_in = 11'(tau);
    taumin_valid_in = 1'b1;
    @(negedge clk_in);
    taumin_valid_in = 1'b0;
    latency = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1;
      if (taumin_valid_out) begin
        latency = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit resetBefore;
    int tau;
    int expOut;
    bit expVoiced;
  } vec_t;

  vec_t vecs [$];

  function automatic void addVec(input bit r, input int tau, input int eo, input bit ev);
    vec_t v;
    v.resetBefore = r;
    v.tau = tau;
    v.expOut = eo;
    v.expVoiced = ev;
    vecs.push_back(v);
  endfunction

  initial begin
    int lat;
    int eo;
    bit ev;
    int tau;
    int pulses;

    rst_in = 1'b0;
    taumin_in = '0;
    taumin_valid_in = 1'b0;
    modelReset();

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_taumin", taumin_out, 0);
    checkOutput("reset_valid", taumin_valid_out, 0);
    checkOutput("reset_voiced", voiced_out, 0);
    checkOutput("reset_overrun", overrun_out, 0);

    // Ramp: bypass while filling, median once full
    addVec(1, 100, 100, 1);
    addVec(0, 101, 101, 1);
    addVec(0, 102, 102, 1);
    addVec(0, 103, 103, 1);
    addVec(0, 104, 102, 1);
    // Octave spike suppressed until it becomes the majority
    addVec(1, 100, 100, 1);
    addVec(0, 100, 100, 1);
    addVec(0, 100, 100, 1);
    addVec(0, 100, 100, 1);
    addVec(0, 100, 100, 1);
    addVec(0, 200, 100, 1);
    addVec(0, 200, 100, 1);
    addVec(0, 200, 200, 1);
    // Dropout hold: seven rejects keep voicing, the eighth drops it
    addVec(1, 150, 150, 1);
    addVec(0, 10,   150, 1);
    addVec(0, 2047, 150, 1);
    addVec(0, 10,   150, 1);
    addVec(0, 2047, 150, 1);
    addVec(0, 10,   150, 1);
    addVec(0, 2047, 150, 1);
    addVec(0, 10,   150, 1);
    addVec(0, 2047, 150, 0);
    addVec(0, 300,  300, 1);
    // Range boundaries
    addVec(1, 19,   0,    0);
    addVec(1, 2001, 0,    0);
    addVec(0, 20,   20,   1);
    addVec(0, 2000, 2000, 1);
    addVec(0, 19,   2000, 1);

    rst_in = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].resetBefore) doReset();
      applyStimulus(vecs[i].tau, 1'b0, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 7);
      checkOutput($sformatf("vec%0d_taumin", i), taumin_out, vecs[i].expOut);
      checkOutput($sformatf("vec%0d_voiced", i), voiced_out, vecs[i].expVoiced);
      @(posedge clk_in);
      #1;
      checkOutput($sformatf("vec%0d_pulse_width", i), taumin_valid_out, 0);
    end

    // Randomized stimulus against the model, with a reject-heavy stretch
    doReset();
    for (int i = 0; i < 60; i++) begin
      int r = int'($urandom_range(0, 99));
      int rejPct = (i >= 20 && i < 35) ? 85 : 25;
      repeat (int'($urandom_range(0, 3))) @(negedge clk_in);
      if (r < rejPct) begin
        tau = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 19))
                                          : int'($urandom_range(2001, 2047));
      end else if (r < rejPct + 35) begin
        tau = int'($urandom_range(95, 105));
      end else begin
        tau = int'($urandom_range(20, 2000));
      end
      modelStep(tau, eo, ev);
      applyStimulus(tau, 1'b0, lat);
      checkOutput($sformatf("rand%0d_latency", i), lat, 7);
      checkOutput($sformatf("rand%0d_taumin", i), taumin_out, eo);
      checkOutput($sformatf("rand%0d_voiced", i), voiced_out, ev);
    end

    // Overrun: second strobe at N+3 is dropped, the flag sticks
    doReset();
    checkOutput("ovr_clear", overrun_out, 0);
    @(negedge clk_in);
    taumin_in = 11'd500;
    taumin_valid_in = 1'b1;
    @(posedge clk_in);
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_in);
      taumin_valid_in = (k == 3);
      taumin_in = (k == 3) ? 11'd900 : 11'd500;
      @(posedge clk_in);
      #1;
      if (k < 7 && taumin_valid_out) pulses++;
      if (k == 7) begin
        checkOutput("ovr_pulse_n7", taumin_valid_out, 1);
        checkOutput("ovr_taumin", taumin_out, 500);
        checkOutput("ovr_voiced", voiced_out, 1);
      end
    end
    checkOutput("ovr_early_pulses", pulses, 0);
    checkOutput("ovr_flag", overrun_out, 1);
    applyStimulus(600, 1'b0, lat);
    checkOutput("ovr_next_latency", lat, 7);
    checkOutput("ovr_next_taumin", taumin_out, 600);
    checkOutput("ovr_sticky", overrun_out, 1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in);
      #1;
      if (taumin_valid_out) pulses++;
    end
    checkOutput("ovr_no_extra_pulse", pulses, 0);

    // Reset at N+4 aborts the update
    @(negedge clk_in);
    taumin_in = 11'd700;
    taumin_valid_in = 1'b1;
    @(posedge clk_in);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      taumin_valid_in = 1'b0;
      if (k == 4) rst_in = 1'b0;
      @(posedge clk_in);
    end
    #1;
    checkOutput("midrst_taumin", taumin_out, 0);
    checkOutput("midrst_valid", taumin_valid_out, 0);
    checkOutput("midrst_voiced", voiced_out, 0);
    checkOutput("midrst_overrun", overrun_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in);
      #1;
      if (taumin_valid_out) pulses++;
    end
    checkOutput("midrst_no_pulse", pulses, 0);

    // Strobe on the cycle reset deasserts is sampled normally
    @(negedge clk_in);
    rst_in = 1'b0;
    applyStimulus(800, 1'b1, lat);
    checkOutput("rstrel_latency", lat, 7);
    checkOutput("rstrel_taumin", taumin_out, 800);
    checkOutput("rstrel_voiced", voiced_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule : tb_taumin_tracker
